multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM control unit for the multicycle ARM datapath (shared ALU/memory; IR, Data, A, ALUOut regs).
//  Sequences fetch/decode/execute per instruction; supports LDR/STR, DP (ADD,SUB,AND,ORR,MOV), B, BL.
//  Owns NZCV flags and conditional-execution gating. Sits between the instruction register and datapath enables.
// PARAMETERS
//  ENABLE_BL   1   1: BL runs LINK state (R14 <- PC+4); 0: BL decodes as B
//  NEVER_COND  1   1: Cond=4'b1111 never executes; 0: treated as AL
// PORTS
//  clk        in   1  clock, rising edge
//  reset_n    in   1  async active-low reset (one clock; reset is asynchronous and active-low)
//  Cond       in   4  Instr[31:28]
//  Op         in   2  Instr[27:26]
//  Funct      in   6  Instr[25:20]
//  Rd         in   4  Instr[15:12]
//  ALUFlags   in   4  NZCV from ALU, current cycle
//  PCWrite    out  1  PC register enable
//  MemWrite   out  1  memory write enable
//  RegWrite   out  1  register file write enable
//  IRWrite    out  1  instruction register enable
//  AdrSrc     out  1  0: PC, 1: ALUOut as memory address
//  RegSrc     out  2  [0]=1 read R15 as RA1; [1]=1 read Rd as RA2 (STR)
//  ALUSrcA    out  1  0: A reg, 1: PC
//  ALUSrcB    out  2  0: WriteData, 1: ExtImm, 2: const 4, 3: const 0
//  ResultSrc  out  2  0: ALUOut, 1: Data reg, 2: ALUResult
//  ImmSrc     out  2  = Op
//  ALUControl out  3  ADD 000, SUB 001, AND 010, ORR 011, MOV 101
//  bl         out  1  write address forced to R14 (LINK state only)
//  illegal    out  1  1-cycle pulse on unimplemented instruction
//  state_o    out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECR6 EXECI7 ALUWB8 BRANCH9 LINK10.
//  reset_n low: state=FETCH, flags=0000, cond_q=0; all enables (PCWrite,MemWrite,RegWrite,IRWrite), bl, illegal forced 0.
//  FETCH: IRWrite=1,PCWrite=1,AdrSrc=0,ALUSrcA=1,ALUSrcB=2,ResultSrc=2,ALUControl=ADD -> DECODE.
//  DECODE: ALUSrcA=1,ALUSrcB=2,ResultSrc=2 (R15=PC+8); latch cond_q=condcheck(Cond,flags).
//   Op=00: Funct[5]? EXECI : EXECR; Op=01: Funct[0]? MEMADR(ld) : MEMADR(st);
//   Op=10: Funct[4]&ENABLE_BL? LINK : BRANCH; Op=11 or unsupported DP Funct[4:1]: illegal=1 -> FETCH.
//  MEMADR: ALUSrcA=0,ALUSrcB=1,ADD -> MEMRD (LDR) / MEMWR (STR).
//  MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=1, RegWrite=cond_q -> FETCH.
//  MEMWR: AdrSrc=1, MemWrite=cond_q -> FETCH.
//  EXECR: ALUSrcA=0,ALUSrcB=0; EXECI: ALUSrcB=1; both -> ALUWB; flags captured this cycle if cond_q:
//   Funct[0] updates N,Z; Funct[0]&(ADD|SUB) also updates C,V.
//  ALUWB: ResultSrc=0, RegWrite=cond_q -> FETCH.
//  LINK: ALUSrcA=1,ALUSrcB=3,ResultSrc=2,bl=1,RegWrite=cond_q (R14<-PC+4) -> BRANCH.
//  BRANCH: ALUSrcA=0,ALUSrcB=1,ResultSrc=2,RegSrc[0]=1,PCWrite=cond_q -> FETCH.
//  Writeback with Rd=15 (MEMWB/ALUWB): PCWrite=cond_q, RegWrite=0.
//  CPI: LDR 5, STR 4, DP 4, B 3, BL 4, illegal 2. Outputs are pure functions of state, Op, Funct, Rd, cond_q.
//  Cond failed: sequence still completes, all state-changing writes (Reg/Mem/PC/flags) suppressed.
//  Non-DP states drive ALUControl=ADD. reset_n mid-instruction: abort immediately, no partial writes after.
// TESTING
//  Reset asserted in MEMRD -> state_o=0 same cycle, all enables 0; release -> FETCH IRWrite=1 on next edge.
//  ADD R1,R2,#5 (Op=00,Funct=101000,Cond=1110) -> states 0,1,7,8; RegWrite=1 only in ALUWB; flags unchanged.
//  SUBS result 0 then BEQ -> Z=1 latched; branch states 0,1,9 with PCWrite=1 in BRANCH; BNE same -> PCWrite=0.
//  LDR then STR (Op=01) -> LDR 0,1,2,3,4 RegWrite in MEMWB; STR 0,1,2,5 MemWrite=1 in MEMWR, RegSrc[1]=1.
//  BL (Op=10,Funct[4]=1) -> 0,1,10,9; LINK bl=1,ALUSrcB=3,RegWrite=1; ENABLE_BL=0 -> 0,1,9, no RegWrite.
//  Op=11 and DP Funct[4:1]=0111 -> illegal=1 one cycle in DECODE, next state FETCH, no writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for a multicycle ARM datapath (LDR/STR, DP, B, BL).
// In: clk, reset_n, Cond, Op, Funct, Rd, ALUFlags. Out: datapath enables/muxes, bl, illegal, state_o.
module multicycle_controller #(
    parameter bit ENABLE_BL  = 1'b1,
    parameter bit NEVER_COND = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       bl,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_LINK   = 4'd10;

    logic [3:0] state, state_n;
    logic [3:0] flags;
    logic       cond_q;
    logic       cond_ok;
    logic [3:0] cmd;
    logic       dp_ok;
    logic       arith;
    logic [2:0] alu_dec;
    logic       flag_we;
    logic       wb_pc, wb_reg;
    logic       pc_w, mem_w, reg_w, ir_w, bl_r, ill_r;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = cy;
            4'h3:    cond_eval = !cy;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = cy && !z;
            4'h9:    cond_eval = !cy || z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z && (n == v);
            4'hD:    cond_eval = z || (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = !NEVER_COND;
        endcase
    endfunction

    assign cond_ok = cond_eval(Cond, flags);
    assign cmd     = Funct[4:1];

    always_comb begin
        dp_ok   = 1'b1;
        alu_dec = 3'b000;
        case (cmd)
            4'b0100: alu_dec = 3'b000;
            4'b0010: alu_dec = 3'b001;
            4'b0000: alu_dec = 3'b010;
            4'b1100: alu_dec = 3'b011;
            4'b1101: alu_dec = 3'b101;
            default: dp_ok   = 1'b0;
        endcase
    end

    assign arith   = (cmd == 4'b0100) || (cmd == 4'b0010);
    assign flag_we = cond_q && Funct[0] &&
                     ((state == S_EXECR) || (state == S_EXECI));

    // A writeback to R15 is a jump: steer it to the PC instead of the file.
    assign wb_pc  = cond_q && (Rd == 4'hF);
    assign wb_reg = cond_q && (Rd != 4'hF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_FETCH;
            flags  <= 4'b0000;
            cond_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_DECODE)
                cond_q <= cond_ok;
            if (flag_we) begin
                flags[3:2] <= ALUFlags[3:2];
                if (arith)
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_n    = S_FETCH;
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        ir_w       = 1'b0;
        bl_r       = 1'b0;
        ill_r      = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = {(Op == 2'b01) && !Funct[0], 1'b0};
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ResultSrc  = 2'd0;
        ALUControl = 3'b000;
        unique case (state)
            S_FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                unique case (Op)
                    2'b00: begin
                        if (!dp_ok)
                            ill_r = 1'b1;
                        else
                            state_n = Funct[5] ? S_EXECI : S_EXECR;
                    end
                    2'b01: state_n = S_MEMADR;
                    2'b10: state_n = (Funct[4] && ENABLE_BL) ? S_LINK : S_BRANCH;
                    default: ill_r = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'd1;
                state_n = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'd1;
                reg_w     = wb_reg;
                pc_w      = wb_pc;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = cond_q;
            end
            S_EXECR: begin
                ALUControl = alu_dec;
                state_n    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'd1;
                ALUControl = alu_dec;
                state_n    = S_ALUWB;
            end
            S_ALUWB: begin
                ALUControl = alu_dec;
                reg_w      = wb_reg;
                pc_w       = wb_pc;
            end
            S_LINK: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd3;
                ResultSrc = 2'd2;
                bl_r      = 1'b1;
                reg_w     = cond_q;
                state_n   = S_BRANCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                RegSrc[0] = 1'b1;
                pc_w      = cond_q;
            end
            default: state_n = S_FETCH;
        endcase
    end

    // Enables are squashed while reset is held so nothing writes during abort.
    assign PCWrite  = pc_w  && reset_n;
    assign MemWrite = mem_w && reset_n;
    assign RegWrite = reg_w && reset_n;
    assign IRWrite  = ir_w  && reset_n;
    assign bl       = bl_r  && reset_n;
    assign illegal  = ill_r && reset_n;
    assign ImmSrc   = Op;
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
// Per-cycle vectors of instruction fields with expected state and control outputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] Cond = 4'hE;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;

    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, bl, illegal;
    logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    logic       b_pcw, b_mw, b_rw, b_irw, b_adr, b_sa, b_bl, b_ill;
    logic [1:0] b_rs, b_sb, b_res, b_imm;
    logic [2:0] b_alu;
    logic [3:0] b_st;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .bl(bl), .illegal(illegal),
        .state_o(state_o)
    );

    multicycle_controller #(.ENABLE_BL(1'b0)) dut_nobl (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(b_pcw), .MemWrite(b_mw),
        .RegWrite(b_rw), .IRWrite(b_irw), .AdrSrc(b_adr), .RegSrc(b_rs),
        .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ResultSrc(b_res),
        .ImmSrc(b_imm), .ALUControl(b_alu), .bl(b_bl), .illegal(b_ill),
        .state_o(b_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] c;
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] r;
        logic [3:0] fl;
        logic [3:0] st;
        logic [6:0] en;
        logic [9:0] mux;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail = 0;

    logic [3:0] ic;
    logic [1:0] io;
    logic [5:0] ifn;
    logic [3:0] ir;

    // en  = {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,bl,illegal}
    // mux = {RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
    task automatic v(input logic [3:0] fl, input logic [3:0] st,
                     input logic [6:0] en, input logic [1:0] rs,
                     input logic sa, input logic [1:0] sb,
                     input logic [1:0] res, input logic [2:0] alu);
        vec_t e;
        e.c = ic; e.o = io; e.f = ifn; e.r = ir; e.fl = fl;
        e.st = st; e.en = en; e.mux = {rs, sa, sb, res, alu};
        vq.push_back(e);
    endtask

    task automatic ins(input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r,
                       input logic [1:0] rs, input logic ill);
        ic = c; io = o; ifn = f; ir = r;
        v(4'h0, 4'd0, 7'b1001000, rs, 1'b1, 2'd2, 2'd2, 3'b000);
        v(4'h0, 4'd1, {6'b0, ill}, rs, 1'b1, 2'd2, 2'd2, 3'b000);
    endtask

    task automatic br(input logic [3:0] c, input logic pcw);
        ins(c, 2'b10, 6'b100000, 4'd0, 2'b00, 1'b0);
        v(4'h0, 4'd9, {pcw, 6'b0}, 2'b01, 1'b0, 2'd1, 2'd2, 3'b000);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] en_a();
        return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, bl, illegal};
    endfunction

    function automatic logic [9:0] mux_a();
        return {RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
    endfunction

    initial begin
        // ADD R1,R2,#5 : S=0, ALU flags ignored
        ins(4'hE, 2'b00, 6'b101000, 4'd1, 2'b00, 1'b0);
        v(4'b0110, 4'd7, 7'b0, 2'b00, 1'b0, 2'd1, 2'd0, 3'b000);
        v(4'h0, 4'd8, 7'b0010000, 2'b00, 1'b0, 2'd0, 2'd0, 3'b000);
        br(4'h0, 1'b0);
        // SUBS R3,R3,R3 -> Z=1,C=1
        ins(4'hE, 2'b00, 6'b000101, 4'd3, 2'b00, 1'b0);
        v(4'b0110, 4'd6, 7'b0, 2'b00, 1'b0, 2'd0, 2'd0, 3'b001);
        v(4'h0, 4'd8, 7'b0010000, 2'b00, 1'b0, 2'd0, 2'd0, 3'b001);
        br(4'h0, 1'b1);
        br(4'h1, 1'b0);
        // LDR R4
        ins(4'hE, 2'b01, 6'b011001, 4'd4, 2'b00, 1'b0);
        v(4'h0, 4'd2, 7'b0, 2'b00, 1'b0, 2'd1, 2'd0, 3'b000);
        v(4'h0, 4'd3, 7'b0000100, 2'b00, 1'b0, 2'd0, 2'd0, 3'b000);
        v(4'h0, 4'd4, 7'b0010000, 2'b00, 1'b0, 2'd0, 2'd1, 3'b000);
        // STR R4
        ins(4'hE, 2'b01, 6'b011000, 4'd4, 2'b10, 1'b0);
        v(4'h0, 4'd2, 7'b0, 2'b10, 1'b0, 2'd1, 2'd0, 3'b000);
        v(4'h0, 4'd5, 7'b0100100, 2'b10, 1'b0, 2'd0, 2'd0, 3'b000);
        // BL
        ins(4'hE, 2'b10, 6'b110000, 4'd0, 2'b00, 1'b0);
        v(4'h0, 4'd10, 7'b0010010, 2'b00, 1'b1, 2'd3, 2'd2, 3'b000);
        v(4'h0, 4'd9, 7'b1000000, 2'b01, 1'b0, 2'd1, 2'd2, 3'b000);
        // Op=11 and unsupported DP cmd 0111
        ins(4'hE, 2'b11, 6'b000000, 4'd0, 2'b00, 1'b1);
        ins(4'hE, 2'b00, 6'b001110, 4'd0, 2'b00, 1'b1);
        // LDR PC
        ins(4'hE, 2'b01, 6'b011001, 4'd15, 2'b00, 1'b0);
        v(4'h0, 4'd2, 7'b0, 2'b00, 1'b0, 2'd1, 2'd0, 3'b000);
        v(4'h0, 4'd3, 7'b0000100, 2'b00, 1'b0, 2'd0, 2'd0, 3'b000);
        v(4'h0, 4'd4, 7'b1000000, 2'b00, 1'b0, 2'd0, 2'd1, 3'b000);
        // STRNE (Z=1, fails)
        ins(4'h1, 2'b01, 6'b011000, 4'd4, 2'b10, 1'b0);
        v(4'h0, 4'd2, 7'b0, 2'b10, 1'b0, 2'd1, 2'd0, 3'b000);
        v(4'h0, 4'd5, 7'b0000100, 2'b10, 1'b0, 2'd0, 2'd0, 3'b000);
        // SUBSNE fails: flags must keep Z=1
        ins(4'h1, 2'b00, 6'b000101, 4'd3, 2'b00, 1'b0);
        v(4'b0000, 4'd6, 7'b0, 2'b00, 1'b0, 2'd0, 2'd0, 3'b001);
        v(4'h0, 4'd8, 7'b0, 2'b00, 1'b0, 2'd0, 2'd0, 3'b001);
        br(4'h0, 1'b1);
        br(4'hF, 1'b0);
        // ADDS R1,R1,#1 -> clears NZCV
        ins(4'hE, 2'b00, 6'b101001, 4'd1, 2'b00, 1'b0);
        v(4'b0000, 4'd7, 7'b0, 2'b00, 1'b0, 2'd1, 2'd0, 3'b000);
        v(4'h0, 4'd8, 7'b0010000, 2'b00, 1'b0, 2'd0, 2'd0, 3'b000);
        br(4'h0, 1'b0);
        br(4'h1, 1'b1);
        // ANDS with C,V from ALU: logical op must not touch C
        ins(4'hE, 2'b00, 6'b000001, 4'd2, 2'b00, 1'b0);
        v(4'b0011, 4'd6, 7'b0, 2'b00, 1'b0, 2'd0, 2'd0, 3'b010);
        v(4'h0, 4'd8, 7'b0010000, 2'b00, 1'b0, 2'd0, 2'd0, 3'b010);
        br(4'h2, 1'b0);
        // ORR R2 reg, MOV PC,#imm
        ins(4'hE, 2'b00, 6'b011000, 4'd2, 2'b00, 1'b0);
        v(4'h0, 4'd6, 7'b0, 2'b00, 1'b0, 2'd0, 2'd0, 3'b011);
        v(4'h0, 4'd8, 7'b0010000, 2'b00, 1'b0, 2'd0, 2'd0, 3'b011);
        ins(4'hE, 2'b00, 6'b111010, 4'd15, 2'b00, 1'b0);
        v(4'h0, 4'd7, 7'b0, 2'b00, 1'b0, 2'd1, 2'd0, 3'b101);
        v(4'h0, 4'd8, 7'b1000000, 2'b00, 1'b0, 2'd0, 2'd0, 3'b101);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {28'd0, state_o}, 32'd0);
        chk("rst_en", {25'd0, en_a()}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            Cond = vq[i].c; Op = vq[i].o; Funct = vq[i].f;
            Rd = vq[i].r; ALUFlags = vq[i].fl;
            #1;
            chk($sformatf("v%0d_state", i), {28'd0, state_o}, {28'd0, vq[i].st});
            chk($sformatf("v%0d_en", i), {25'd0, en_a()}, {25'd0, vq[i].en});
            chk($sformatf("v%0d_mux", i), {22'd0, mux_a()}, {22'd0, vq[i].mux});
            chk($sformatf("v%0d_imm", i), {30'd0, ImmSrc}, {30'd0, vq[i].o});
            @(posedge clk);
            #1;
        end

        // Reset in MEMRD aborts the LDR at once
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd4; ALUFlags = 4'h0;
        #1;
        chk("ab_fetch", {28'd0, state_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ab_memrd", {28'd0, state_o}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk("ab_state", {28'd0, state_o}, 32'd0);
        chk("ab_en", {25'd0, en_a()}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ab_rel_irw", {31'd0, IRWrite}, 32'd1);
        @(posedge clk);
        #1;
        chk("ab_dec", {28'd0, state_o}, 32'd1);
        chk("ab_dec_en", {25'd0, en_a()}, 32'd0);

        // BL without LINK support behaves as B
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        Cond = 4'hE; Op = 2'b10; Funct = 6'b110000; Rd = 4'd0;
        #1;
        chk("nobl_fetch", {28'd0, b_st}, 32'd0);
        @(posedge clk);
        #1;
        chk("nobl_dec", {28'd0, b_st}, 32'd1);
        @(posedge clk);
        #1;
        chk("nobl_br", {28'd0, b_st}, 32'd9);
        chk("nobl_en", {25'd0, b_pcw, b_mw, b_rw, b_irw, b_adr, b_bl, b_ill},
            {25'd0, 7'b1000000});
        @(posedge clk);
        #1;
        chk("nobl_next", {28'd0, b_st}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
